// File: rtl/k_means_regfile.sv
// rtl/k_means_regfile.sv - host register file and RAM/core sequencer for the k-means engine
//
// Purpose: host-visible register bank (status, go, 8 centroids, RAM address/data,
// point range, threshold) with a small FSM that issues single-cycle RAM write
// strobes, starts a core run and collects the core's completion interrupt.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   host_sel/host_wr/host_addr  host access strobe, direction, register number
//   host_wdata/host_rdata       host write data / registered read data
//   host_ready                  access accepted this cycle (low during a RAM strobe)
//   irq                         run-complete interrupt (mirrors status.done)
//   adress2core/data2core       RAM address and RAM/centroid data towards the core
//   go_core                     high while the core is running
//   first/last_ram_address      point range registers
//   threshold_value             convergence threshold register
//   W_R_RAM_N/CHIP_SEL_RAM_N    active-low RAM write enable and chip select
//   reg_num/reg_w_r             core register select and write strobe
//   Reg_write_data_from_core    core centroid write data
//   interupt                    core done pulse

module k_means_regfile #(
  parameter int dataWidth       = 91,
  parameter int addrWidth       = 9,
  parameter int manhatten_width = 16,
  parameter int reg_amount      = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       host_sel,
  input  logic                       host_wr,
  input  logic [reg_amount-1:0]      host_addr,
  input  logic [dataWidth-1:0]       host_wdata,
  output logic [dataWidth-1:0]       host_rdata,
  output logic                       host_ready,
  output logic                       irq,
  output logic [dataWidth-1:0]       adress2core,
  output logic [dataWidth-1:0]       data2core,
  output logic                       go_core,
  output logic [addrWidth-1:0]       first_ram_address,
  output logic [addrWidth-1:0]       last_ram_address,
  output logic [manhatten_width-1:0] threshold_value,
  output logic                       W_R_RAM_N,
  output logic                       CHIP_SEL_RAM_N,
  input  logic [reg_amount-1:0]      reg_num,
  input  logic                       reg_w_r,
  input  logic [dataWidth-1:0]       Reg_write_data_from_core,
  input  logic                       interupt
);

  localparam logic [reg_amount-1:0] A_STATUS   = reg_amount'(0);
  localparam logic [reg_amount-1:0] A_GO       = reg_amount'(1);
  localparam logic [reg_amount-1:0] A_CENT1    = reg_amount'(2);
  localparam logic [reg_amount-1:0] A_RAM_ADDR = reg_amount'(10);
  localparam logic [reg_amount-1:0] A_RAM_DATA = reg_amount'(11);
  localparam logic [reg_amount-1:0] A_FIRST    = reg_amount'(12);
  localparam logic [reg_amount-1:0] A_LAST     = reg_amount'(13);
  localparam logic [reg_amount-1:0] A_THRESH   = reg_amount'(14);

  typedef enum logic [1:0] {IDLE, RAM_WR, RUN, DONE} state_t;

  state_t                     state;
  logic [dataWidth-1:0]       cent [8];
  logic [addrWidth-1:0]       ram_addr;
  logic [dataWidth-1:0]       ram_data;
  logic [addrWidth-1:0]       first_addr;
  logic [addrWidth-1:0]       last_addr;
  logic [manhatten_width-1:0] threshold;
  logic                       done;
  logic                       cfg_err;
  logic                       access_err;

  logic                       running;
  logic                       wr_acc;
  logic                       rd_acc;
  logic                       locked_reg;
  logic [dataWidth-1:0]       rd_mux;
  logic [dataWidth-1:0]       core_cent;

  assign running    = (state == RUN);
  assign host_ready = (state != RAM_WR);
  assign wr_acc     = host_sel & host_ready & host_wr;
  assign rd_acc     = host_sel & host_ready & ~host_wr;

  // Registers the core depends on while running: go and the RAM/range/threshold block.
  assign locked_reg = (host_addr == A_GO) ||
                      ((host_addr >= A_RAM_ADDR) && (host_addr <= A_THRESH));

  assign go_core           = running;
  assign irq               = done;
  assign first_ram_address = first_addr;
  assign last_ram_address  = last_addr;
  assign threshold_value   = threshold;

  always_comb begin
    rd_mux = '0;
    case (host_addr)
      A_STATUS:   rd_mux = dataWidth'({access_err, cfg_err, running, done});
      A_GO:       rd_mux = dataWidth'(running);
      A_RAM_ADDR: rd_mux = dataWidth'(ram_addr);
      A_RAM_DATA: rd_mux = ram_data;
      A_FIRST:    rd_mux = dataWidth'(first_addr);
      A_LAST:     rd_mux = dataWidth'(last_addr);
      A_THRESH:   rd_mux = dataWidth'(threshold);
      default: begin
        for (int i = 0; i < 8; i++) begin
          if (host_addr == A_CENT1 + reg_amount'(i)) rd_mux = cent[i];
        end
      end
    endcase
  end

  // Centroid lookup for the core; anything outside 2..9 reads as zero.
  always_comb begin
    core_cent = '0;
    for (int i = 0; i < 8; i++) begin
      if (reg_num == A_CENT1 + reg_amount'(i)) core_cent = cent[i];
    end
  end

  always_comb begin
    adress2core    = '0;
    data2core      = '0;
    W_R_RAM_N      = 1'b1;
    CHIP_SEL_RAM_N = 1'b1;
    if (state == RAM_WR) begin
      adress2core    = dataWidth'(ram_addr);
      data2core      = ram_data;
      W_R_RAM_N      = 1'b0;
      CHIP_SEL_RAM_N = 1'b0;
    end else if (running && !reg_w_r) begin
      data2core = core_cent;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      host_rdata <= '0;
      ram_addr   <= '0;
      ram_data   <= '0;
      first_addr <= '0;
      last_addr  <= '0;
      threshold  <= '0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      access_err <= 1'b0;
      for (int i = 0; i < 8; i++) cent[i] <= '0;
    end else begin
      host_rdata <= rd_acc ? rd_mux : '0;

      if (wr_acc) begin
        if (running && locked_reg) begin
          access_err <= 1'b1;
        end else begin
          case (host_addr)
            A_STATUS: begin
              if (host_wdata[0]) done       <= 1'b0;
              if (host_wdata[2]) cfg_err    <= 1'b0;
              if (host_wdata[3]) access_err <= 1'b0;
            end
            A_GO:       ;
            A_RAM_ADDR: ram_addr   <= host_wdata[addrWidth-1:0];
            A_RAM_DATA: ram_data   <= host_wdata;
            A_FIRST:    first_addr <= host_wdata[addrWidth-1:0];
            A_LAST:     last_addr  <= host_wdata[addrWidth-1:0];
            A_THRESH:   threshold  <= host_wdata[manhatten_width-1:0];
            default: begin
              for (int i = 0; i < 8; i++) begin
                if (host_addr == A_CENT1 + reg_amount'(i)) cent[i] <= host_wdata;
              end
            end
          endcase
        end
      end

      // Core capture comes after the host path so it wins a same-cycle collision.
      if (running && reg_w_r) begin
        for (int i = 0; i < 8; i++) begin
          if (reg_num == A_CENT1 + reg_amount'(i)) cent[i] <= Reg_write_data_from_core;
        end
      end

      case (state)
        IDLE: begin
          if (wr_acc && host_addr == A_RAM_DATA) begin
            state <= RAM_WR;
          end else if (wr_acc && host_addr == A_GO && host_wdata[0]) begin
            if (first_addr <= last_addr) state <= RUN;
            else                         cfg_err <= 1'b1;
          end
        end
        RAM_WR: begin
          ram_addr <= ram_addr + addrWidth'(1);
          state    <= IDLE;
        end
        RUN: begin
          // Setting done here overrides a same-cycle write-1-to-clear.
          if (interupt) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_k_means_regfile.sv
// tb/tb_k_means_regfile.sv - self-checking bench for k_means_regfile
module tb_k_means_regfile;

  localparam int DW = 91;

  logic          clk;
  logic          rst_n;
  logic          host_sel;
  logic          host_wr;
  logic [7:0]    host_addr;
  logic [DW-1:0] host_wdata;
  logic [DW-1:0] host_rdata;
  logic          host_ready;
  logic          irq;
  logic [DW-1:0] adress2core;
  logic [DW-1:0] data2core;
  logic          go_core;
  logic [8:0]    first_ram_address;
  logic [8:0]    last_ram_address;
  logic [15:0]   threshold_value;
  logic          W_R_RAM_N;
  logic          CHIP_SEL_RAM_N;
  logic [7:0]    reg_num;
  logic          reg_w_r;
  logic [DW-1:0] Reg_write_data_from_core;
  logic          interupt;

  k_means_regfile dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .host_sel                 (host_sel),
    .host_wr                  (host_wr),
    .host_addr                (host_addr),
    .host_wdata               (host_wdata),
    .host_rdata               (host_rdata),
    .host_ready               (host_ready),
    .irq                      (irq),
    .adress2core              (adress2core),
    .data2core                (data2core),
    .go_core                  (go_core),
    .first_ram_address        (first_ram_address),
    .last_ram_address         (last_ram_address),
    .threshold_value          (threshold_value),
    .W_R_RAM_N                (W_R_RAM_N),
    .CHIP_SEL_RAM_N           (CHIP_SEL_RAM_N),
    .reg_num                  (reg_num),
    .reg_w_r                  (reg_w_r),
    .Reg_write_data_from_core (Reg_write_data_from_core),
    .interupt                 (interupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int bad_we = 0;

  // Reference model state
  logic [DW-1:0] m_cent [8];
  int            m_ram_addr;
  logic [DW-1:0] m_ram_data;
  int            m_first;
  int            m_last;
  int            m_thr;
  bit            m_done, m_cfg, m_acc, m_run;

  logic [DW-1:0] exp_a[$], exp_d[$], act_a[$], act_d[$];

  always @(negedge clk) begin
    if (CHIP_SEL_RAM_N === 1'b0) begin
      act_a.push_back(adress2core);
      act_d.push_back(data2core);
    end
    if (W_R_RAM_N !== CHIP_SEL_RAM_N) bad_we++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {27'($urandom()), $urandom(), $urandom()};
  endfunction

  function automatic logic [DW-1:0] model_read(input int a);
    if (a == 0)       return DW'({m_acc, m_cfg, m_run, m_done});
    else if (a == 1)  return DW'(m_run);
    else if (a <= 9)  return m_cent[a-2];
    else if (a == 10) return DW'(m_ram_addr);
    else if (a == 11) return m_ram_data;
    else if (a == 12) return DW'(m_first);
    else if (a == 13) return DW'(m_last);
    else if (a == 14) return DW'(m_thr);
    else              return '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_cent[i] = '0;
    m_ram_addr = 0; m_ram_data = '0; m_first = 0; m_last = 0; m_thr = 0;
    m_done = 0; m_cfg = 0; m_acc = 0; m_run = 0;
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 16 && host_ready !== 1'b1; k++) @(negedge clk);
    check("host_ready", DW'(host_ready), DW'(1));
  endtask

  task automatic host_write(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    wait_ready();
    host_sel = 1'b1; host_wr = 1'b1; host_addr = 8'(a); host_wdata = d;
    @(negedge clk);
    host_sel = 1'b0; host_wr = 1'b0;
    if (a == 0) begin
      if (d[0]) m_done = 0;
      if (d[2]) m_cfg = 0;
      if (d[3]) m_acc = 0;
    end else if (m_run && (a == 1 || (a >= 10 && a <= 14))) begin
      m_acc = 1;
    end else if (a == 1) begin
      if (d[0]) begin
        if (m_first <= m_last) m_run = 1;
        else                   m_cfg = 1;
      end
    end else if (a <= 9) begin
      m_cent[a-2] = d;
    end else if (a == 10) begin
      m_ram_addr = int'(d[8:0]);
    end else if (a == 11) begin
      m_ram_data = d;
      exp_a.push_back(DW'(m_ram_addr));
      exp_d.push_back(d);
      m_ram_addr = (m_ram_addr + 1) % 512;
    end else if (a == 12) begin
      m_first = int'(d[8:0]);
    end else if (a == 13) begin
      m_last = int'(d[8:0]);
    end else if (a == 14) begin
      m_thr = int'(d[15:0]);
    end
  endtask

  task automatic read_check(input int a, input string tag);
    @(negedge clk);
    wait_ready();
    host_sel = 1'b1; host_wr = 1'b0; host_addr = 8'(a);
    @(negedge clk);
    host_sel = 1'b0;
    check(tag, host_rdata, model_read(a));
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".go_core"}, DW'(go_core), DW'(m_run));
    check({tag, ".irq"}, DW'(irq), DW'(m_done));
    check({tag, ".first"}, DW'(first_ram_address), DW'(m_first));
    check({tag, ".last"}, DW'(last_ram_address), DW'(m_last));
    check({tag, ".thr"}, DW'(threshold_value), DW'(m_thr));
  endtask

  task automatic check_strobes(input string tag);
    @(negedge clk);
    #1;
    check({tag, ".count"}, DW'(act_a.size()), DW'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < act_a.size(); i++) begin
      check({tag, ".addr"}, act_a[i], exp_a[i]);
      check({tag, ".data"}, act_d[i], exp_d[i]);
    end
    exp_a.delete(); exp_d.delete(); act_a.delete(); act_d.delete();
  endtask

  task automatic core_write(input int num, input logic [DW-1:0] d);
    @(negedge clk);
    reg_num = 8'(num); reg_w_r = 1'b1; Reg_write_data_from_core = d;
    @(negedge clk);
    reg_w_r = 1'b0;
    if (m_run && num >= 2 && num <= 9) m_cent[num-2] = d;
  endtask

  task automatic core_peek(input int num);
    @(negedge clk);
    reg_num = 8'(num); reg_w_r = 1'b0;
    #1;
    check("core_peek", data2core, (m_run && num >= 2 && num <= 9) ? m_cent[num-2] : '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".go_core"}, DW'(go_core), '0);
    check({tag, ".irq"}, DW'(irq), '0);
    check({tag, ".host_ready"}, DW'(host_ready), DW'(1));
    check({tag, ".host_rdata"}, host_rdata, '0);
    check({tag, ".adress2core"}, adress2core, '0);
    check({tag, ".data2core"}, data2core, '0);
    check({tag, ".we_n"}, DW'(W_R_RAM_N), DW'(1));
    check({tag, ".cs_n"}, DW'(CHIP_SEL_RAM_N), DW'(1));
  endtask

  initial begin
    logic [DW-1:0] d;
    int a;

    rst_n = 1'b0; host_sel = 1'b0; host_wr = 1'b0; host_addr = '0; host_wdata = '0;
    reg_num = '0; reg_w_r = 1'b0; Reg_write_data_from_core = '0; interupt = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i <= 14; i++) read_check(i, "post_reset_read");
    read_check(200, "unmapped_read");

    // RAM address wrap across two back-to-back data writes
    host_write(10, DW'(510));
    host_write(11, rand_data());
    host_write(11, rand_data());
    check_strobes("ram_wrap");
    read_check(10, "ram_addr_wrapped");

    // Random RAM bursts
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 1) host_write(10, DW'($urandom_range(0, 511)));
      host_write(11, rand_data());
    end
    check_strobes("ram_random");

    // Random register traffic, including unmapped addresses
    for (int i = 0; i < 24; i++) begin
      a = $urandom_range(2, 18);
      if (a > 14) a = $urandom_range(15, 255);
      host_write(a, rand_data());
      a = $urandom_range(0, 18);
      if (a > 14) a = $urandom_range(15, 255);
      read_check(a, "random_read");
    end
    check_outputs("after_random");
    check_strobes("random_ram");

    // Inverted range refuses to start
    host_write(12, DW'(5));
    host_write(13, DW'(3));
    host_write(1, DW'(1));
    check_outputs("cfg_err");
    read_check(0, "status_cfg_err");
    host_write(0, DW'(4));
    read_check(0, "status_cfg_cleared");

    // Full run
    host_write(12, DW'(0));
    host_write(13, DW'(99));
    host_write(14, rand_data());
    host_write(1, DW'(1));
    check_outputs("run_start");
    read_check(0, "status_busy");
    core_write(2, DW'(91'h123));
    core_peek(2);
    for (int i = 0; i < 6; i++) begin
      a = $urandom_range(3, 9);
      core_write(a, rand_data());
      core_peek(a);
    end
    core_peek(0);
    core_peek(10);
    core_peek(255);
    host_write(11, rand_data());
    host_write(12, DW'(7));
    check_strobes("ram_locked_in_run");
    check_outputs("locked_regs");
    read_check(0, "status_access_err");
    host_write(0, DW'(8));
    read_check(0, "status_access_cleared");

    // Capture on the same cycle as the done pulse
    d = rand_data();
    @(negedge clk);
    reg_num = 8'd9; reg_w_r = 1'b1; Reg_write_data_from_core = d; interupt = 1'b1;
    @(negedge clk);
    reg_w_r = 1'b0; interupt = 1'b0;
    m_cent[7] = d; m_done = 1; m_run = 0;
    check_outputs("done");
    read_check(9, "cent_8_captured");
    read_check(2, "cent_1_read");
    check(("cent_1_is_123"), m_cent[0], DW'(91'h123));
    read_check(0, "status_done");
    host_write(0, DW'(1));
    check_outputs("irq_cleared");

    // Done pulse outside a run is ignored
    @(negedge clk); interupt = 1'b1;
    @(negedge clk); interupt = 1'b0;
    @(negedge clk);
    check_outputs("stray_interupt");
    read_check(0, "status_stray");

    // Reset in the middle of a run
    host_write(1, DW'(1));
    check_outputs("run_again");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("reset_in_run");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i <= 14; i++) read_check(i, "after_run_reset");

    // Reset while the RAM strobe is active
    host_write(10, DW'($urandom_range(0, 511)));
    d = rand_data();
    @(negedge clk);
    host_sel = 1'b1; host_wr = 1'b1; host_addr = 8'd11; host_wdata = d;
    @(negedge clk);
    host_sel = 1'b0; host_wr = 1'b0;
    exp_a.push_back(DW'(m_ram_addr));
    exp_d.push_back(d);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("reset_in_ram_wr");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_strobes("ram_aborted");
    read_check(10, "ram_addr_after_abort");
    read_check(11, "ram_data_after_abort");

    check("we_matches_cs", DW'(bad_we), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
